// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared ALU.
// Only one command is in flight at a time. The command is issued for one
// cycle, held while the ALU's fixed latency elapses, and its result is then
// parked until the consumer takes it.
module alu_arbiter #(
  parameter int WIDTH   = 8,
  parameter int MUL_LAT = 3,
  parameter int STD_LAT = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               R0_VALID,
  output logic               R0_READY,
  input  logic               R0_MODE,
  input  logic [3:0]         R0_CMD,
  input  logic [1:0]         R0_INP_VALID,
  input  logic               R0_CIN,
  input  logic [WIDTH-1:0]   R0_OPA,
  input  logic [WIDTH-1:0]   R0_OPB,
  input  logic               R1_VALID,
  output logic               R1_READY,
  input  logic               R1_MODE,
  input  logic [3:0]         R1_CMD,
  input  logic [1:0]         R1_INP_VALID,
  input  logic               R1_CIN,
  input  logic [WIDTH-1:0]   R1_OPA,
  input  logic [WIDTH-1:0]   R1_OPB,
  output logic               ALU_CE,
  output logic               ALU_MODE,
  output logic [3:0]         ALU_CMD,
  output logic [1:0]         ALU_INP_VALID,
  output logic               ALU_CIN,
  output logic [WIDTH-1:0]   ALU_OPA,
  output logic [WIDTH-1:0]   ALU_OPB,
  input  logic [2*WIDTH-1:0] ALU_RES,
  input  logic               ALU_ERR,
  input  logic               ALU_OFLOW,
  input  logic               ALU_COUT,
  input  logic               ALU_G,
  input  logic               ALU_E,
  input  logic               ALU_L,
  output logic               RSP_VALID,
  input  logic               RSP_READY,
  output logic               RSP_ID,
  output logic [2*WIDTH-1:0] RSP_RES,
  output logic [5:0]         RSP_FLAGS
);

  localparam int MAXL = (MUL_LAT > STD_LAT) ? MUL_LAT : STD_LAT;
  localparam int CW   = $clog2(MAXL + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               last_q;
  logic               mode_q, cin_q, id_q;
  logic [3:0]         cmd_q;
  logic [1:0]         iv_q;
  logic [WIDTH-1:0]   opa_q, opb_q;
  logic [2*WIDTH-1:0] res_q;
  logic [5:0]         flags_q;

  logic               gnt_id;
  logic               accept;
  logic               wait_done;
  logic [CW-1:0]      lat_ld;

  // Grant selection: a lone requester wins outright, a tie goes to the one not served last
  always_comb begin
    gnt_id = 1'b0;
    if (R0_VALID && R1_VALID) gnt_id = ~last_q;
    else if (R1_VALID)        gnt_id = 1'b1;
  end

  assign accept    = (state_q == IDLE) && (R0_VALID || R1_VALID);
  assign wait_done = (state_q == WAIT) && (cnt_q == CW'(1));
  assign lat_ld    = (mode_q && (cmd_q == 4'd9 || cmd_q == 4'd10)) ? CW'(MUL_LAT) : CW'(STD_LAT);

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic and latency down-counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = ISSUE;
      ISSUE: begin
        cnt_d   = lat_ld;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (wait_done) state_d = RESP;
      end
      RESP:  if (RSP_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command holding, round-robin pointer, counter and response capture
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q   <= '0;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      mode_q  <= 1'b0;
      cmd_q   <= '0;
      iv_q    <= '0;
      cin_q   <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) begin
        last_q <= gnt_id;
        id_q   <= gnt_id;
        mode_q <= gnt_id ? R1_MODE      : R0_MODE;
        cmd_q  <= gnt_id ? R1_CMD       : R0_CMD;
        iv_q   <= gnt_id ? R1_INP_VALID : R0_INP_VALID;
        cin_q  <= gnt_id ? R1_CIN       : R0_CIN;
        opa_q  <= gnt_id ? R1_OPA       : R0_OPA;
        opb_q  <= gnt_id ? R1_OPB       : R0_OPB;
      end
      if (wait_done) begin
        res_q   <= ALU_RES;
        flags_q <= {ALU_ERR, ALU_OFLOW, ALU_COUT, ALU_G, ALU_E, ALU_L};
      end
    end
  end

  // Outputs: handshakes gated by reset so they read 0 while it is asserted
  always_comb begin
    R0_READY      = RST && (state_q == IDLE) && R0_VALID && !gnt_id;
    R1_READY      = RST && (state_q == IDLE) && R1_VALID &&  gnt_id;
    ALU_CE        = (state_q == ISSUE) || (state_q == WAIT);
    ALU_INP_VALID = (state_q == ISSUE) ? iv_q : 2'b00;
    ALU_MODE      = mode_q;
    ALU_CMD       = cmd_q;
    ALU_CIN       = cin_q;
    ALU_OPA       = opa_q;
    ALU_OPB       = opb_q;
    RSP_VALID     = (state_q == RESP);
    RSP_ID        = id_q;
    RSP_RES       = res_q;
    RSP_FLAGS     = flags_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a stand-in ALU that only presents the true result on
// the cycle the arbiter should sample it, a transaction-level reference model,
// directed scenarios with literal expectations, then a random phase.
module tb_alu_arbiter;

  localparam int W  = 8;
  localparam int ML = 3;
  localparam int SL = 1;

  logic CLK = 1'b0;
  logic RST;
  logic R0_VALID, R0_READY, R0_MODE, R0_CIN;
  logic [3:0] R0_CMD;
  logic [1:0] R0_INP_VALID;
  logic [W-1:0] R0_OPA, R0_OPB;
  logic R1_VALID, R1_READY, R1_MODE, R1_CIN;
  logic [3:0] R1_CMD;
  logic [1:0] R1_INP_VALID;
  logic [W-1:0] R1_OPA, R1_OPB;
  logic ALU_CE, ALU_MODE, ALU_CIN;
  logic [3:0] ALU_CMD;
  logic [1:0] ALU_INP_VALID;
  logic [W-1:0] ALU_OPA, ALU_OPB;
  logic [2*W-1:0] ALU_RES;
  logic ALU_ERR, ALU_OFLOW, ALU_COUT, ALU_G, ALU_E, ALU_L;
  logic RSP_VALID, RSP_READY, RSP_ID;
  logic [2*W-1:0] RSP_RES;
  logic [5:0] RSP_FLAGS;

  int n_chk = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  alu_arbiter #(.WIDTH(W), .MUL_LAT(ML), .STD_LAT(SL)) dut (
    .CLK(CLK), .RST(RST),
    .R0_VALID(R0_VALID), .R0_READY(R0_READY), .R0_MODE(R0_MODE), .R0_CMD(R0_CMD),
    .R0_INP_VALID(R0_INP_VALID), .R0_CIN(R0_CIN), .R0_OPA(R0_OPA), .R0_OPB(R0_OPB),
    .R1_VALID(R1_VALID), .R1_READY(R1_READY), .R1_MODE(R1_MODE), .R1_CMD(R1_CMD),
    .R1_INP_VALID(R1_INP_VALID), .R1_CIN(R1_CIN), .R1_OPA(R1_OPA), .R1_OPB(R1_OPB),
    .ALU_CE(ALU_CE), .ALU_MODE(ALU_MODE), .ALU_CMD(ALU_CMD), .ALU_INP_VALID(ALU_INP_VALID),
    .ALU_CIN(ALU_CIN), .ALU_OPA(ALU_OPA), .ALU_OPB(ALU_OPB), .ALU_RES(ALU_RES),
    .ALU_ERR(ALU_ERR), .ALU_OFLOW(ALU_OFLOW), .ALU_COUT(ALU_COUT), .ALU_G(ALU_G),
    .ALU_E(ALU_E), .ALU_L(ALU_L),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID),
    .RSP_RES(RSP_RES), .RSP_FLAGS(RSP_FLAGS)
  );

  // Stand-in ALU behaviour: returns {ERR,OFLOW,COUT,G,E,L,RES}
  function automatic logic [21:0] alu_fn(input logic mode, input logic [3:0] cmd,
                                         input logic [1:0] iv, input logic cin,
                                         input logic [7:0] a, input logic [7:0] b);
    logic [15:0] r;
    logic [15:0] a16, b16;
    a16 = {8'h00, a};
    b16 = {8'h00, b};
    if (mode) begin
      case (cmd)
        4'd0:    r = a16 + b16;
        4'd1:    r = a16 - b16;
        4'd9:    r = (a16 + 16'd1) * b16;
        4'd10:   r = (a16 << 1) * b16;
        default: r = a16 + b16 + {15'h0, cin};
      endcase
    end else begin
      r = {8'h00, cmd[0] ? (a & b) : (a ^ b)};
    end
    return {(iv == 2'b00), (mode && cmd == 4'd1 && a < b), r[8], (a > b), (a == b), (a < b), r};
  endfunction

  function automatic int lat_of(input logic mode, input logic [3:0] cmd);
    return (mode && (cmd == 4'd9 || cmd == 4'd10)) ? ML : SL;
  endfunction

  // Stand-in ALU: true result only on the final latency cycle, corrupted otherwise
  int ce_run = 0;
  logic [1:0] iv_lat = 2'b00;
  logic [15:0] junk_r = 16'h1;
  logic [5:0] junk_f = 6'h1;
  logic [21:0] stub_v;
  logic hit;

  always @(posedge CLK) begin
    junk_r <= 16'($urandom) | 16'h1;
    junk_f <= 6'($urandom) | 6'h1;
    if (ALU_CE && ce_run == 0) iv_lat <= ALU_INP_VALID;
    ce_run <= ALU_CE ? ce_run + 1 : 0;
  end

  assign stub_v  = alu_fn(ALU_MODE, ALU_CMD, iv_lat, ALU_CIN, ALU_OPA, ALU_OPB);
  assign hit     = ALU_CE && (ce_run == lat_of(ALU_MODE, ALU_CMD));
  assign ALU_RES = stub_v[15:0] ^ (hit ? 16'h0 : junk_r);
  assign {ALU_ERR, ALU_OFLOW, ALU_COUT, ALU_G, ALU_E, ALU_L} = stub_v[21:16] ^ (hit ? 6'h0 : junk_f);

  // Reference model: one transaction, m_t counts cycles since its acceptance
  logic m_busy = 1'b0;
  int   m_t = 0;
  int   m_lat = SL;
  logic m_last = 1'b1;
  logic h_id = 1'b0, h_mode = 1'b0, h_cin = 1'b0;
  logic [3:0] h_cmd = '0;
  logic [1:0] h_iv = '0;
  logic [7:0] h_a = '0, h_b = '0;
  logic [21:0] m_rsp = '0;

  function automatic logic grant(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return !last;
    return v1;
  endfunction

  function automatic logic [63:0] outs_all();
    return 64'({R0_READY, R1_READY, ALU_CE, ALU_MODE, ALU_CMD, ALU_INP_VALID, ALU_CIN,
                ALU_OPA, ALU_OPB, RSP_VALID, RSP_ID, RSP_RES, RSP_FLAGS});
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic g;
    if (!RST) begin
      m_busy = 1'b0; m_t = 0; m_last = 1'b1; m_rsp = '0;
      h_id = 1'b0; h_mode = 1'b0; h_cmd = '0; h_iv = '0; h_cin = 1'b0; h_a = '0; h_b = '0;
    end else if (!m_busy) begin
      if (R0_VALID || R1_VALID) begin
        g = grant(R0_VALID, R1_VALID, m_last);
        m_last = g; h_id = g;
        h_mode = g ? R1_MODE : R0_MODE;
        h_cmd  = g ? R1_CMD : R0_CMD;
        h_iv   = g ? R1_INP_VALID : R0_INP_VALID;
        h_cin  = g ? R1_CIN : R0_CIN;
        h_a    = g ? R1_OPA : R0_OPA;
        h_b    = g ? R1_OPB : R0_OPB;
        m_lat  = lat_of(h_mode, h_cmd);
        m_busy = 1'b1; m_t = 1;
      end
    end else if (m_t <= m_lat + 1) begin
      if (m_t == m_lat + 1) m_rsp = alu_fn(h_mode, h_cmd, h_iv, h_cin, h_a, h_b);
      m_t++;
    end else if (RSP_READY) begin
      m_busy = 1'b0;
    end
  endtask

  task automatic compare_all();
    logic g, issue, waitp, resp;
    if (!RST) begin
      chk("reset_outputs", outs_all(), 64'h0);
      return;
    end
    g     = grant(R0_VALID, R1_VALID, m_last);
    issue = m_busy && m_t == 1;
    waitp = m_busy && m_t >= 2 && m_t <= m_lat + 1;
    resp  = m_busy && m_t == m_lat + 2;
    chk("r0_ready", 64'(R0_READY), 64'(!m_busy && R0_VALID && !g));
    chk("r1_ready", 64'(R1_READY), 64'(!m_busy && R1_VALID && g));
    chk("alu_ce", 64'(ALU_CE), 64'(issue || waitp));
    chk("alu_inp_valid", 64'(ALU_INP_VALID), 64'(issue ? h_iv : 2'b00));
    chk("rsp_valid", 64'(RSP_VALID), 64'(resp));
    if (issue || waitp)
      chk("alu_fields", 64'({ALU_MODE, ALU_CMD, ALU_CIN, ALU_OPA, ALU_OPB}),
          64'({h_mode, h_cmd, h_cin, h_a, h_b}));
    if (resp)
      chk("rsp_data", 64'({RSP_ID, RSP_FLAGS, RSP_RES}), 64'({h_id, m_rsp}));
  endtask

  // One clock: check mid-cycle, advance the model on the edge, return just after it
  task automatic cycle();
    @(negedge CLK);
    compare_all();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic wait_rsp(output int k);
    k = 1;
    while (!RSP_VALID && k < 40) begin
      cycle();
      k++;
    end
    chk("rsp_seen", 64'(RSP_VALID), 64'h1);
  endtask

  task automatic set_r0(input logic v, input logic m, input logic [3:0] c, input logic [1:0] iv,
                        input logic [7:0] a, input logic [7:0] b);
    R0_VALID = v; R0_MODE = m; R0_CMD = c; R0_INP_VALID = iv; R0_CIN = 1'b0; R0_OPA = a; R0_OPB = b;
  endtask

  task automatic set_r1(input logic v, input logic m, input logic [3:0] c, input logic [1:0] iv,
                        input logic [7:0] a, input logic [7:0] b);
    R1_VALID = v; R1_MODE = m; R1_CMD = c; R1_INP_VALID = iv; R1_CIN = 1'b0; R1_OPA = a; R1_OPB = b;
  endtask

  task automatic rand_req(output logic m, output logic [3:0] c, output logic [1:0] iv,
                          output logic cin, output logic [7:0] a, output logic [7:0] b);
    m = 1'($urandom);
    case ($urandom_range(0, 3))
      0:       c = 4'd9;
      1:       c = 4'd10;
      2:       c = 4'($urandom_range(0, 1));
      default: c = 4'($urandom);
    endcase
    iv = 2'($urandom); cin = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
  endtask

  initial begin
    int k;
    RST = 1'b0; RSP_READY = 1'b1;
    set_r0(0, 0, 0, 0, 0, 0);
    set_r1(0, 0, 0, 0, 0, 0);
    #1;
    chk("reset_async_zero", outs_all(), 64'h0);
    cycle(); cycle();
    RST = 1'b1;

    // ADD from R0 alone
    set_r0(1, 1, 4'd0, 2'b11, 8'h05, 8'h03);
    #1;
    chk("s1_r0_ready", 64'(R0_READY), 64'h1);
    cycle();
    R0_VALID = 1'b0;
    wait_rsp(k);
    chk("s1_latency", 64'(k), 64'(SL + 2));
    chk("s1_res", 64'(RSP_RES), 64'h0008);
    chk("s1_id", 64'(RSP_ID), 64'h0);
    cycle();

    // Simultaneous requests right after reset, then a third tie
    RST = 1'b0; #1; cycle(); RST = 1'b1;
    set_r0(1, 1, 4'd0, 2'b11, 8'h01, 8'h02);
    set_r1(1, 1, 4'd1, 2'b11, 8'h09, 8'h04);
    #1;
    chk("s2_tie_r0_ready", 64'(R0_READY), 64'h1);
    chk("s2_tie_r1_ready", 64'(R1_READY), 64'h0);
    cycle();
    R0_VALID = 1'b0;
    wait_rsp(k);
    chk("s2_first_id", 64'(RSP_ID), 64'h0);
    cycle();
    chk("s2_r1_ready", 64'(R1_READY), 64'h1);
    cycle();
    R1_VALID = 1'b0;
    wait_rsp(k);
    chk("s2_r1_id", 64'(RSP_ID), 64'h1);
    chk("s2_r1_res", 64'(RSP_RES), 64'h0005);
    cycle();
    R0_VALID = 1'b1; R1_VALID = 1'b1;
    #1;
    chk("s2_third_tie_r0", 64'(R0_READY), 64'h1);
    chk("s2_third_tie_r1", 64'(R1_READY), 64'h0);
    cycle();
    R0_VALID = 1'b0; R1_VALID = 1'b0;
    wait_rsp(k);
    cycle();

    // Multiply from R1
    set_r1(1, 1, 4'd9, 2'b11, 8'h03, 8'h04);
    cycle();
    R1_VALID = 1'b0;
    wait_rsp(k);
    chk("s3_latency", 64'(k), 64'(ML + 2));
    chk("s3_res", 64'(RSP_RES), 64'h0010);
    chk("s3_id", 64'(RSP_ID), 64'h1);
    cycle();

    // Consumer back-pressure with both requesters waiting
    RSP_READY = 1'b0;
    set_r0(1, 1, 4'd0, 2'b11, 8'h10, 8'h20);
    cycle();
    R0_VALID = 1'b0;
    wait_rsp(k);
    R0_VALID = 1'b1; R1_VALID = 1'b1;
    repeat (5) cycle();
    chk("s4_hold_valid", 64'(RSP_VALID), 64'h1);
    chk("s4_hold_res", 64'(RSP_RES), 64'h0030);
    chk("s4_hold_ready", 64'({R0_READY, R1_READY}), 64'h0);
    RSP_READY = 1'b1; R0_VALID = 1'b0; R1_VALID = 1'b0;
    cycle();
    chk("s4_released", 64'(RSP_VALID), 64'h0);

    // Reset during WAIT
    set_r1(1, 1, 4'd10, 2'b11, 8'h02, 8'h03);
    cycle();
    R1_VALID = 1'b0;
    cycle();
    chk("s5_in_wait", 64'(ALU_CE), 64'h1);
    RST = 1'b0;
    #1;
    chk("s5_async_zero", outs_all(), 64'h0);
    cycle();
    RST = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("s5_no_stale", 64'(RSP_VALID), 64'h0);
    end
    set_r1(1, 1, 4'd1, 2'b11, 8'h07, 8'h02);
    #1;
    chk("s5_r1_ready", 64'(R1_READY), 64'h1);
    cycle();
    R1_VALID = 1'b0;
    wait_rsp(k);
    chk("s5_res", 64'(RSP_RES), 64'h0005);
    cycle();

    // No-operand command forwarded; ALU error reported in flags
    set_r0(1, 1, 4'd0, 2'b00, 8'h01, 8'h01);
    cycle();
    R0_VALID = 1'b0;
    wait_rsp(k);
    chk("s6_err_flag", 64'(RSP_FLAGS[5]), 64'h1);
    cycle();

    // Random traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      logic m, cin;
      logic [3:0] c;
      logic [1:0] iv;
      logic [7:0] a, b;
      RST = ($urandom_range(0, 149) != 0);
      RSP_READY = ($urandom_range(0, 2) != 0);
      rand_req(m, c, iv, cin, a, b);
      R0_VALID = ($urandom_range(0, 2) == 0); R0_MODE = m; R0_CMD = c; R0_INP_VALID = iv;
      R0_CIN = cin; R0_OPA = a; R0_OPB = b;
      rand_req(m, c, iv, cin, a, b);
      R1_VALID = ($urandom_range(0, 2) == 0); R1_MODE = m; R1_CMD = c; R1_INP_VALID = iv;
      R1_CIN = cin; R1_OPA = a; R1_OPB = b;
      cycle();
    end

    RST = 1'b1; RSP_READY = 1'b1; R0_VALID = 1'b0; R1_VALID = 1'b0;
    repeat (10) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, operand width of the shared ALU.
REQ-002 Parameter MUL_LAT, default 3, ALU result latency in cycles for multiply commands (MODE=1, CMD=9 or 10).
REQ-003 Parameter STD_LAT, default 1, ALU result latency in cycles for all other commands.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RST  input  1  asynchronous, active-low reset.
REQ-006 Rn_VALID  input  1  requester n (n=0,1) presents a command.
REQ-007 Rn_READY  output  1  arbiter accepts requester n's command this cycle.
REQ-008 Rn_MODE, Rn_CMD, Rn_INP_VALID, Rn_CIN  input  1/4/2/1  command fields of requester n.
REQ-009 Rn_OPA, Rn_OPB  input  WIDTH each  operands of requester n.
REQ-010 ALU_CE, ALU_MODE, ALU_CMD, ALU_INP_VALID, ALU_CIN  output  1/1/4/2/1  drive to shared ALU.
REQ-011 ALU_OPA, ALU_OPB  output  WIDTH each  operands to shared ALU.
REQ-012 ALU_RES  input  2*WIDTH  ALU result; ALU_ERR, ALU_OFLOW, ALU_COUT, ALU_G, ALU_E, ALU_L  input  1 each  ALU flags.
REQ-013 RSP_VALID  output  1  response available; RSP_READY  input  1  consumer takes response.
REQ-014 RSP_ID  output  1  requester index owning the response.
REQ-015 RSP_RES  output  2*WIDTH; RSP_FLAGS  output  6  = {ERR,OFLOW,COUT,G,E,L}.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; exactly one transaction in flight at any time.
REQ-017 Rn_READY SHALL be high only in IDLE and only for the granted requester; combinational from state, R0_VALID, R1_VALID, pointer.
REQ-018 Grant: single VALID -> that requester; both VALID -> requester not most recently accepted (round-robin); pointer updates only on acceptance.
REQ-019 Acceptance (VALID & READY in IDLE) SHALL capture MODE/CMD/INP_VALID/CIN/OPA/OPB and requester ID into holding registers; next state ISSUE.
REQ-020 IDLE with no VALID SHALL stay IDLE, ALU_CE=0, ALU_INP_VALID=0.
REQ-021 ISSUE lasts exactly 1 cycle: ALU_CE=1, ALU_INP_VALID=captured value, all ALU_* fields from holding registers; next state WAIT.
REQ-022 WAIT: ALU_CE=1, ALU_INP_VALID=0, ALU_OPA/OPB/MODE/CMD/CIN held stable; lasts MUL_LAT cycles for MODE=1 with CMD 9/10, else STD_LAT cycles, via down-counter loaded at ISSUE.
REQ-023 On last WAIT cycle edge, ALU_RES and flags SHALL be captured into RSP_RES/RSP_FLAGS; next state RESP.
REQ-024 RESP: RSP_VALID=1, RSP_ID/RSP_RES/RSP_FLAGS stable, ALU_CE=0; hold until RSP_READY=1, then IDLE on that edge.
REQ-025 Rn_READY SHALL be 0 in ISSUE, WAIT, RESP regardless of VALID; new requests wait, no queueing.
REQ-026 Commands with Rn_INP_VALID=2'b00 SHALL be forwarded unchanged; error reporting is solely via ALU_ERR in RSP_FLAGS.
REQ-027 Minimum accept-to-RSP_VALID latency: STD_LAT+2 cycles; minimum back-to-back acceptance spacing: STD_LAT+3 cycles with RSP_READY tied high.
REQ-028 VALID deasserted before acceptance SHALL withdraw the request without state change.

Reset
REQ-029 RST=0 SHALL immediately, without clock, force IDLE, round-robin pointer so requester 0 wins first tie, and clear counter and holding registers.
REQ-030 During reset all outputs SHALL be 0: Rn_READY, ALU_*, RSP_VALID, RSP_ID, RSP_RES, RSP_FLAGS.
REQ-031 Reset mid-transaction SHALL discard the in-flight command and any pending response; no RSP_VALID after release for it.
REQ-032 First acceptance SHALL occur no earlier than the first rising edge after RST returns high.

Verification
REQ-033 R0 only: MODE=1, CMD=0 (ADD), OPA=8'h05, OPB=8'h03, INP_VALID=2'b11 -> RSP_VALID 3 cycles after accept, RSP_ID=0, RSP_RES=16'h0008.
REQ-034 R0 and R1 VALID same cycle from reset, R1 MODE=1 CMD=1 OPA=8'h09 OPB=8'h04 -> R0 served first, then R1 with RSP_RES=16'h0005, RSP_ID=1; third tie grants R0.
REQ-035 R1 MODE=1 CMD=9, OPA=8'h03, OPB=8'h04 -> ALU_INP_VALID high one cycle, WAIT 3 cycles, RSP_RES per ALU multiply (16'h0010), operands stable throughout.
REQ-036 RSP_READY held 0 for 5 cycles in RESP -> RSP_VALID and data stable, both Rn_READY 0; RSP_READY=1 -> IDLE next cycle.
REQ-037 RST low during WAIT -> all outputs 0 asynchronously; after release no stale RSP_VALID; next R1 request accepted normally.
REQ-038 R0 INP_VALID=2'b00 -> forwarded, RSP_FLAGS[5] equals ALU_ERR.
